// File: rtl/opc_history_if.sv
`default_nettype none
// ============================================================================
//  Module      : opc_history_if
//  Description : Bundle of capture, control and spy-read signals between the
//                old-PC save path / debugger and the opc_history buffer.
//                  opc_in, opc_stb      capture value and strobe
//                  freeze, clr          capture inhibit and history clear
//                  rd_req, rd_age       read request and entry age (0 newest)
//                  rd_data, rd_valid,
//                  rd_miss              registered read result
//                  count, wrapped       occupancy and overwrite flag
//                The master modport drives requests; the slave modport is the
//                buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface opc_history_if #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] opc_in;
    logic             opc_stb;
    logic             freeze;
    logic             clr;
    logic             rd_req;
    logic [AW-1:0]    rd_age;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_miss;
    logic [AW:0]      count;
    logic             wrapped;

    modport master (
        output opc_in, opc_stb, freeze, clr, rd_req, rd_age,
        input  rd_data, rd_valid, rd_miss, count, wrapped
    );

    modport slave (
        input  opc_in, opc_stb, freeze, clr, rd_req, rd_age,
        output rd_data, rd_valid, rd_miss, count, wrapped
    );
endinterface : opc_history_if
`default_nettype wire

// File: rtl/opc_history.sv
`default_nettype none
// ============================================================================
//  Module      : opc_history
//  Description : Circular history of the last DEPTH saved PC values. Every
//                opc_stb (unless frozen or cleared) writes opc_in at the write
//                pointer. Reads address entries by age, 0 being the newest,
//                and return a registered result one cycle later.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high
//                bus    - opc_history_if.slave (capture, control, read, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module opc_history #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    opc_history_if.slave   bus
);

    localparam logic [AW:0]   c_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_WP_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW:0]      r_count;
    logic             r_wrapped;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_rd_miss;

    logic             w_cap;
    logic [AW-1:0]    w_rd_idx;
    logic             w_rd_hit;

    // A clear in the same cycle wins over a capture; a frozen strobe is lost.
    assign w_cap    = bus.opc_stb & ~bus.freeze & ~bus.clr;

    // r_wp points at the next free slot, so the newest entry is r_wp-1.
    // All of this uses pre-edge state, so a read in a capture or clear
    // cycle sees the buffer as it was before the edge.
    assign w_rd_idx = r_wp - c_WP_ONE - bus.rd_age;
    assign w_rd_hit = ({1'b0, bus.rd_age} < r_count);

    // Storage is deliberately not reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!reset && w_cap) begin
            r_mem[r_wp] <= bus.opc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp       <= '0;
            r_count    <= '0;
            r_wrapped  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
        end else begin
            if (bus.clr) begin
                r_wp      <= '0;
                r_count   <= '0;
                r_wrapped <= 1'b0;
            end else if (w_cap) begin
                r_wp <= r_wp + c_WP_ONE;
                // Full buffer: this write overwrites the oldest entry.
                if (r_count == c_DEPTH) begin
                    r_wrapped <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            if (bus.rd_req) begin
                r_rd_valid <= 1'b1;
                if (w_rd_hit) begin
                    r_rd_data <= r_mem[w_rd_idx];
                    r_rd_miss <= 1'b0;
                end else begin
                    r_rd_data <= '0;
                    r_rd_miss <= 1'b1;
                end
            end else begin
                // rd_data intentionally holds its last value.
                r_rd_valid <= 1'b0;
                r_rd_miss  <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_miss  = r_rd_miss;
    assign bus.count    = r_count;
    assign bus.wrapped  = r_wrapped;

endmodule : opc_history
`default_nettype wire

// File: tb/tb_opc_history.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opc_history
//  Description : Directed self-checking bench for opc_history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opc_history;

    localparam int c_WIDTH = 14;
    localparam int c_DEPTH = 8;
    localparam int c_AW    = 3;

    logic clk;
    logic reset;

    int n_vec;
    int n_miss;

    opc_history_if #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .AW(c_AW)) bus ();

    opc_history #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .AW(c_AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [c_WIDTH-1:0] v);
        bus.opc_in  = v;
        bus.opc_stb = 1'b1;
        tick();
        bus.opc_stb = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [c_AW-1:0] age,
                      input logic [c_WIDTH-1:0] exp_data, input logic exp_miss);
        bus.rd_req = 1'b1;
        bus.rd_age = age;
        tick();
        bus.rd_req = 1'b0;
        check({tag, ".valid"}, 32'(bus.rd_valid), 32'(1));
        check({tag, ".data"},  32'(bus.rd_data),  32'(exp_data));
        check({tag, ".miss"},  32'(bus.rd_miss),  32'(exp_miss));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset       = 1'b1;
        bus.opc_in  = '0;
        bus.opc_stb = 1'b0;
        bus.freeze  = 1'b0;
        bus.clr     = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_age  = '0;

        // Reset state
        do_reset();
        check("rst.count",    32'(bus.count),    32'(0));
        check("rst.wrapped",  32'(bus.wrapped),  32'(0));
        check("rst.rd_valid", 32'(bus.rd_valid), 32'(0));
        check("rst.rd_data",  32'(bus.rd_data),  32'(0));
        check("rst.rd_miss",  32'(bus.rd_miss),  32'(0));

        // Three captures, reads by age, one past the end
        strobe(14'h0100);
        strobe(14'h0101);
        strobe(14'h0102);
        check("t1.count",   32'(bus.count),   32'(3));
        check("t1.wrapped", 32'(bus.wrapped), 32'(0));
        rd("t1.age0", 3'd0, 14'h0102, 1'b0);
        rd("t1.age1", 3'd1, 14'h0101, 1'b0);
        rd("t1.age2", 3'd2, 14'h0100, 1'b0);
        rd("t1.age1b", 3'd1, 14'h0101, 1'b0);
        // No request: valid drops, data holds
        tick();
        check("t1.idle.valid", 32'(bus.rd_valid), 32'(0));
        check("t1.idle.data",  32'(bus.rd_data),  32'(14'h0101));
        rd("t1.age3", 3'd3, 14'h0000, 1'b1);

        // Ten back-to-back captures overflow the 8 entries
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.opc_in  = 14'(14'h2000 + i);
            bus.opc_stb = 1'b1;
            tick();
            if (i == 7) begin
                check("t2.full.count",   32'(bus.count),   32'(8));
                check("t2.full.wrapped", 32'(bus.wrapped), 32'(0));
            end
        end
        bus.opc_stb = 1'b0;
        check("t2.count",   32'(bus.count),   32'(8));
        check("t2.wrapped", 32'(bus.wrapped), 32'(1));
        rd("t2.age0", 3'd0, 14'h2009, 1'b0);
        rd("t2.age3", 3'd3, 14'h2006, 1'b0);
        rd("t2.age7", 3'd7, 14'h2002, 1'b0);

        // Clear, then freeze drops a strobe
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("t3.clr.count",   32'(bus.count),   32'(0));
        check("t3.clr.wrapped", 32'(bus.wrapped), 32'(0));
        bus.freeze = 1'b1;
        strobe(14'h0AAA);
        check("t3.frz.count", 32'(bus.count), 32'(0));
        bus.freeze = 1'b0;
        strobe(14'h0BBB);
        check("t3.count", 32'(bus.count), 32'(1));
        bus.freeze = 1'b1;
        rd("t3.age0", 3'd0, 14'h0BBB, 1'b0);
        bus.freeze = 1'b0;
        rd("t3.age1", 3'd1, 14'h0000, 1'b1);

        // Read and capture in the same cycle sees the pre-capture buffer
        strobe(14'h0011);
        bus.opc_in  = 14'h0022;
        bus.opc_stb = 1'b1;
        rd("t4.same", 3'd0, 14'h0011, 1'b0);
        bus.opc_stb = 1'b0;
        rd("t4.next", 3'd0, 14'h0022, 1'b0);
        check("t4.count", 32'(bus.count), 32'(3));

        // clr + strobe + read together after 5 captures
        strobe(14'h0033);
        strobe(14'h0044);
        check("t5.count5", 32'(bus.count), 32'(5));
        bus.clr     = 1'b1;
        bus.opc_in  = 14'h0055;
        bus.opc_stb = 1'b1;
        rd("t5.preclr", 3'd0, 14'h0044, 1'b0);
        bus.clr     = 1'b0;
        bus.opc_stb = 1'b0;
        check("t5.count",   32'(bus.count),   32'(0));
        check("t5.wrapped", 32'(bus.wrapped), 32'(0));
        rd("t5.age0", 3'd0, 14'h0000, 1'b1);

        // Reset with a pending read after 4 captures
        strobe(14'h0061);
        strobe(14'h0062);
        strobe(14'h0063);
        strobe(14'h0064);
        check("t6.count4", 32'(bus.count), 32'(4));
        rd("t6.pre", 3'd1, 14'h0063, 1'b0);
        reset      = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_age = 3'd0;
        tick();
        reset      = 1'b0;
        bus.rd_req = 1'b0;
        check("t6.rst.valid", 32'(bus.rd_valid), 32'(0));
        check("t6.rst.data",  32'(bus.rd_data),  32'(0));
        check("t6.rst.count", 32'(bus.count),    32'(0));
        tick();
        check("t6.after.valid", 32'(bus.rd_valid), 32'(0));
        rd("t6.age0", 3'd0, 14'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_opc_history
`default_nettype wire

// File: doc/opc_history.md
# opc_history

Old-PC history buffer, downstream of the old-PC save register. Each time the save register loads a new PC it raises a strobe; this block records that value in a DEPTH-entry circular buffer, so the last DEPTH saved PCs stay available. The spy/debug interface reads entries by age: 0 is the newest capture. Capture can be frozen and cleared independently of reads.

## Interface
- WIDTH, 14, width of a saved PC.
- DEPTH, 8, number of history entries; power of two, at least 2.
- AW, 3, log2(DEPTH).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- opc_in  in  WIDTH  PC value held by the save register.
- opc_stb  in  1  capture opc_in at this edge; one pulse per save-register load.
- freeze  in  1  inhibits capture while high; asserted by the debugger or the inhibit path.
- clr  in  1  synchronous clear of the history; contents are not reset.
- rd_req  in  1  read request, one cycle.
- rd_age  in  AW  age of the requested entry; 0 is the newest.
- rd_data  out  WIDTH  read result, registered.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- rd_miss  out  1  with rd_valid: the requested age has no capture yet.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- wrapped  out  1  sticky flag: at least one entry has been overwritten since the last reset or clr.

## Operation
- State:
  - storage mem[0..DEPTH-1]
  - write pointer wp (AW bits)
  - count
  - wrapped
  - output registers rd_data, rd_valid, rd_miss
- Priority at each edge: reset > clr > capture. Reads are evaluated independently of capture.
- Capture happens when opc_stb & ~freeze & ~clr:
  - mem[wp] <= opc_in
  - wp <= wp+1, wrapping modulo DEPTH
  - count <= min(count+1, DEPTH)
  - if count == DEPTH before the write, wrapped <= 1
- freeze high: opc_stb is ignored and the strobe is lost, not queued. Reads still work.
- clr high:
  - wp <= 0, count <= 0, wrapped <= 0
  - a capture requested in the same cycle is dropped
  - a read in the same cycle is served from the pre-clear state
- Read when rd_req:
  - compute index = (wp - 1 - rd_age) mod DEPTH from the pre-edge wp
  - if rd_age < count (pre-edge): rd_data <= mem[index], rd_miss <= 0
  - otherwise: rd_data <= 0, rd_miss <= 1
  - in both cases rd_valid <= 1
- No rd_req: rd_valid <= 0 and rd_miss <= 0; rd_data holds its last value.
- Read and capture in the same cycle: the read sees the pre-capture buffer, so age 0 returns the entry that was newest before the edge.
- Arithmetic:
  - pointer arithmetic is AW-bit and wraps
  - count saturates at DEPTH and never wraps
  - opc_in is stored unmodified
- reset:
  - wp, count, wrapped, rd_data, rd_valid, rd_miss all go to 0; mem is not cleared
  - captures and reads in the reset cycle are discarded
  - reset in mid-operation discards any read request made that cycle

## Timing
- Capture latency: opc_stb sampled at edge N; the value is readable by an rd_req at edge N+1 and appears on rd_data after edge N+1.
- Read latency: one cycle. rd_req at edge N gives rd_data, rd_valid and rd_miss valid from edge N until edge N+1.
- count and wrapped update at the same edge as the capture that changes them.
- Back-to-back: opc_stb may be high on every cycle, and rd_req may be high on every cycle. Throughput is one capture plus one read per cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then strobe 0x0100, 0x0101, 0x0102 on consecutive cycles, then read ages 0, 1, 2, 3 -> rd_data = 0x0102, 0x0101, 0x0100, then 0 with rd_miss=1; count = 3; wrapped = 0.
- Strobe 10 values 0x2000..0x2009 -> count = 8; wrapped = 1; age 0 = 0x2009; age 7 = 0x2002.
- Strobe 0x0AAA with freeze=1 and 0x0BBB with freeze=0 -> only 0x0BBB is stored; count increments by 1.
- In one cycle, with 0x0011 already the newest entry: opc_stb with 0x0022 plus rd_req age 0 -> rd_data = 0x0011. The next read of age 0 -> 0x0022.
- clr and opc_stb together after 5 captures -> count = 0, wrapped = 0; a read of age 0 gives rd_miss=1, rd_data=0.
- Assert reset while rd_req is high after 4 captures -> rd_valid stays 0 in the following cycle; count = 0.
